// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB
// with req/ack memory handshakes, retired-instruction counting and traps.
module core_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_en,
    output logic             pc_en,
    output logic             reg_we_en,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST =
        WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] CAUSE_ILL  = 2'd1;
    localparam logic [1:0] CAUSE_IMEM = 2'd2;
    localparam logic [1:0] CAUSE_DMEM = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [1:0]    cause_nxt;
    logic [WW-1:0] wcnt;
    logic [6:0]    op_q;
    logic          wait_exp;
    logic          waiting;
    logic          op_mem;
    logic          op_store;
    logic          op_nowb;

    function automatic logic legal_op(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: ok = 1'b1;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign op_store = (op_q == OP_STORE);
    assign op_mem   = (op_q == OP_LOAD) || op_store;
    assign op_nowb  = op_store || (op_q == OP_BRANCH);

    assign wait_exp = (TIMEOUT != 0) && (wcnt == WAIT_LAST);

    // A cycle in which a request is outstanding and not yet acknowledged
    assign waiting = ((state == S_FETCH) && !imem_ack)
                  || ((state == S_MEM) && !dmem_ack);

    // The only Mealy term: IR loads in the very cycle fetch data arrives
    assign ir_en = imem_req & imem_ack;

    always_comb begin
        nxt       = state;
        cause_nxt = trap_cause;
        case (state)
            S_IDLE: begin
                if (run) nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    nxt = S_DECODE;
                end else if (wait_exp) begin
                    nxt       = S_TRAP;
                    cause_nxt = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (legal_op(opcode)) begin
                    nxt = S_EXEC;
                end else begin
                    nxt       = S_TRAP;
                    cause_nxt = CAUSE_ILL;
                end
            end
            S_EXEC: begin
                nxt = op_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    nxt = S_WB;
                end else if (wait_exp) begin
                    nxt       = S_TRAP;
                    cause_nxt = CAUSE_DMEM;
                end
            end
            S_WB: begin
                nxt = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                nxt = S_TRAP;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so each one is a pure
    // decode of the current state as seen from outside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            wcnt       <= '0;
            instret    <= '0;
            trap_cause <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            pc_en      <= 1'b0;
            reg_we_en  <= 1'b0;
            busy       <= 1'b0;
            trap       <= 1'b0;
        end else begin
            state      <= nxt;
            trap_cause <= cause_nxt;

            if (state == S_DECODE) op_q <= opcode;

            if (waiting && (nxt == state)) begin
                wcnt <= wcnt + 1'b1;
            end else begin
                wcnt <= '0;
            end

            if (state == S_WB) instret <= instret + 1'b1;

            imem_req  <= (nxt == S_FETCH);
            dmem_req  <= (nxt == S_MEM);
            dmem_we   <= (nxt == S_MEM) && op_store;
            pc_en     <= (nxt == S_WB);
            reg_we_en <= (nxt == S_WB) && !op_nowb;
            busy      <= (nxt != S_IDLE) && (nxt != S_TRAP);
            trap      <= (nxt == S_TRAP);
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: per-instruction expected timelines built from
// ack delays and opcode class, with random don't-care inputs.
module tb_core_seq_ctrl;

    localparam int T  = 16;
    localparam int CW = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    localparam logic [6:0] LEGAL [9] = '{
        7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
        7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011
    };

    typedef struct packed {
        logic          imem_req;
        logic          dmem_req;
        logic          dmem_we;
        logic          ir_en;
        logic          pc_en;
        logic          reg_we_en;
        logic          busy;
        logic          trap;
        logic [1:0]    cause;
        logic [CW-1:0] instret;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [6:0]    opcode;
    logic          imem_req;
    logic          imem_ack;
    logic          dmem_req;
    logic          dmem_we;
    logic          dmem_ack;
    logic          ir_en;
    logic          pc_en;
    logic          reg_we_en;
    logic          busy;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] m_instret;
    logic          m_trap;
    logic [1:0]    m_cause;

    always #5 clk = ~clk;

    core_seq_ctrl #(.TIMEOUT(T), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .reg_we_en  (reg_we_en),
        .busy       (busy),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, check all outputs, advance to next negedge
    task automatic cyc(input string tag,
                       input logic i_req, input logic d_req,
                       input logic we, input logic ir,
                       input logic pc, input logic rwe,
                       input logic bsy,
                       input logic ra, input logic ia, input logic da);
        obs_t o;
        obs_t e;
        run      = ra;
        imem_ack = ia;
        dmem_ack = da;
        #1;
        o = '{imem_req, dmem_req, dmem_we, ir_en, pc_en, reg_we_en,
              busy, trap, trap_cause, instret};
        e = '{i_req, d_req, we, ir, pc, rwe, bsy,
              m_trap, m_cause, m_instret};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
        @(negedge clk);
    endtask

    task automatic idle_cyc(input logic ra);
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            ra, rnd(), rnd());
    endtask

    task automatic trap_hold(input int n);
        repeat (n)
            cyc("trap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                rnd(), rnd(), rnd());
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        run      = rnd();
        imem_ack = rnd();
        dmem_ack = rnd();
        @(negedge clk);
        rst_n     = 1'b1;
        m_instret = '0;
        m_trap    = 1'b0;
        m_cause   = 2'd0;
        cyc("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, rnd(), rnd());
    endtask

    // Starts with the DUT in FETCH. fw/mw = ack wait cycles before the ack.
    task automatic do_instr(input logic [6:0] op, input int fw,
                            input int mw, input logic run_after);
        logic st;
        logic mem;
        logic nowb;
        st   = (op == OP_STORE);
        mem  = (op == OP_LOAD) || st;
        nowb = st || (op == OP_BRANCH);
        opcode = op;
        for (int k = 0; k <= fw && k < T; k++)
            cyc("fetch", 1'b1, 1'b0, 1'b0, (k == fw), 1'b0, 1'b0, 1'b1,
                rnd(), (k == fw), rnd());
        if (fw >= T) begin
            m_trap  = 1'b1;
            m_cause = 2'd2;
            return;
        end
        cyc("decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            rnd(), rnd(), rnd());
        if (!is_legal(op)) begin
            m_trap  = 1'b1;
            m_cause = 2'd1;
            return;
        end
        cyc("exec", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            rnd(), rnd(), rnd());
        if (mem) begin
            for (int k = 0; k <= mw && k < T; k++)
                cyc("mem", 1'b0, 1'b1, st, 1'b0, 1'b0, 1'b0, 1'b1,
                    rnd(), rnd(), (k == mw));
            if (mw >= T) begin
                m_trap  = 1'b1;
                m_cause = 2'd3;
                return;
            end
        end
        cyc("wb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, !nowb, 1'b1,
            run_after, rnd(), rnd());
        m_instret = m_instret + 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        run      = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        opcode   = '0;
        m_instret = '0;
        m_trap    = 1'b0;
        m_cause   = 2'd0;
        @(negedge clk);
        do_reset();

        // Three back-to-back ALU ops, then LOAD/STORE with waits, BRANCH
        idle_cyc(1'b1);
        repeat (3) do_instr(OP_REG, 0, 0, 1'b1);
        do_instr(OP_LOAD, 0, 3, 1'b1);
        do_instr(OP_STORE, 1, 2, 1'b1);
        do_instr(OP_BRANCH, 0, 0, 1'b0);
        idle_cyc(1'b0);
        idle_cyc(1'b1);

        // Ack arriving on the last allowed wait cycle must not trap
        do_instr(OP_LOAD, T - 1, T - 1, 1'b1);
        do_instr(OP_IMM, T - 1, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic ra;
            ra = rnd();
            do_instr(LEGAL[$urandom_range(0, 8)], $urandom_range(0, 4),
                     $urandom_range(0, 4), ra);
            if (!ra) begin
                repeat ($urandom_range(0, 2)) idle_cyc(1'b0);
                idle_cyc(1'b1);
            end
        end

        // Illegal opcode: sticky trap until reset
        do_instr(OP_BAD, 0, 0, 1'b1);
        trap_hold(6);
        do_reset();

        // Fetch timeout
        idle_cyc(1'b1);
        do_instr(OP_REG, 0, 0, 1'b1);
        do_instr(OP_REG, T, 0, 1'b1);
        trap_hold(4);
        do_reset();

        // Data-memory timeout
        idle_cyc(1'b1);
        do_instr(OP_STORE, 0, T + 4, 1'b1);
        trap_hold(4);
        do_reset();

        // Reset in the middle of a MEM wait
        idle_cyc(1'b1);
        do_instr(OP_IMM, 2, 0, 1'b1);
        opcode = OP_LOAD;
        cyc("fetch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
            rnd(), 1'b1, rnd());
        cyc("decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            rnd(), rnd(), rnd());
        cyc("exec", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            rnd(), rnd(), rnd());
        repeat (3)
            cyc("mem", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                rnd(), rnd(), 1'b0);
        do_reset();
        idle_cyc(1'b0);

        // run dropped mid-instruction: completes, then idles
        idle_cyc(1'b1);
        do_instr(OP_REG, 1, 0, 1'b0);
        idle_cyc(1'b0);
        idle_cyc(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath; turns it into a FETCH/DECODE/EXEC/MEM/WB machine so instruction and data memories may have variable latency (req/ack).
- Gates the datapath's PC update, instruction-register load, register-file write and data-memory access.
- Counts retired instructions.
- Traps on illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, 16: max wait cycles for imem_ack/dmem_ack before trapping; 0 disables timeout.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  1 = execute; sampled only in IDLE and at WB exit
- opcode  in  7  instr[6:0] from decoder, valid from DECODE onward
- imem_req  out  1  fetch request
- imem_ack  in  1  fetch data valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, qualified by dmem_req
- dmem_ack  in  1  data access complete this cycle (load data valid)
- ir_en  out  1  load instruction register
- pc_en  out  1  commit pc_new into pc_reg
- reg_we_en  out  1  AND-gate for datapath RegWrite
- busy  out  1  state != IDLE and != TRAP
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; all outputs 0; instret=0; trap_cause=0; wait counter=0.
  - Reset mid-transaction drops req the next cycle; no handshake completion is owed.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: outputs 0. run=1 → FETCH.
- FETCH:
  - imem_req=1; ir_en = imem_ack (same cycle).
  - imem_ack=1 → DECODE.
  - Else if TIMEOUT≠0 and wait counter = TIMEOUT-1 → TRAP, cause 2.
- DECODE: latch opcode into op_q.
  - Legal opcodes: 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH.
  - Illegal → TRAP, cause 1. Legal → EXEC.
- EXEC: one cycle. op_q LOAD/STORE → MEM, else → WB.
- MEM:
  - dmem_req=1; dmem_we=(op_q==STORE).
  - dmem_ack=1 → WB.
  - Timeout → TRAP, cause 3.
- WB:
  - pc_en=1; instret += 1 (wraps modulo 2^CNT_W).
  - reg_we_en=1 unless op_q is STORE or BRANCH.
  - Next: run=1 → FETCH, else → IDLE.
- TRAP:
  - trap=1; all other control outputs 0; busy=0.
  - Sticky; exits only via reset. run and acks are ignored.
- Moore outputs are decoded from state; ir_en is the only Mealy term (FETCH & imem_ack).
- Outputs are pulses of exactly one cycle per instruction: pc_en, reg_we_en, ir_en.
- Handshake:
  - req rises on state entry and is held until the ack cycle; it is low the following cycle.
  - Ack outside FETCH/MEM is ignored.
  - A request is never withdrawn except on trap or reset.
- Wait counter:
  - Clears on entry to FETCH/MEM; increments each cycle req is high without ack.
  - Ack in the same cycle the counter reaches TIMEOUT-1 wins; no trap.
- Latency with same-cycle ack:
  - ALU/branch/jump/U-type: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE: 5 cycles.
  - Each ack wait cycle adds 1.
- run deassertion mid-instruction has no effect until WB completes.
- instret never increments for trapped instructions.

Test Plan:
- Reset, then run=1, imem_ack tied 1, opcode=0110011 for 3 instructions → state sequence IDLE,FETCH,DECODE,EXEC,WB repeats; pc_en every 4th cycle; instret=3 after 13 cycles.
- LOAD (0000011) with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, reg_we_en=1 in WB; total 8 cycles. STORE → dmem_we=1, reg_we_en=0.
- BRANCH (1100011) → pc_en=1, reg_we_en=0 in WB; instret+1.
- opcode=1111111 → TRAP after DECODE, trap=1, trap_cause=1, instret unchanged; further run/acks have no effect until rst_n=0.
- TIMEOUT=16, imem_ack never asserted → imem_req high 16 cycles, then trap_cause=2. Repeat with ack on the 16th cycle → no trap, DECODE entered.
- rst_n=0 during MEM wait → next cycle dmem_req=0, state IDLE, instret=0. Also: run dropped during EXEC → instruction completes WB, then IDLE with busy=0.
